eth_mac_tx: RTL

// - MAC transmit path of the Ethernet controller: takes frame bytes from the data-link layer and drives the MII/GMII transmit side toward the PHY.
// - Adds the preamble and the SFD, pads short frames to the Ethernet minimum, appends the CRC-32 FCS and enforces the inter-frame gap.
// - It is the parametrised successor of the original stub MAC: MII nibble or GMII byte lanes, configurable minimum payload and IFG, and underrun handling.

---
 rtl/eth_pkg.sv | 32 +++
 rtl/eth_crc32.sv | 27 ++
 rtl/eth_mac_tx.sv | 210 +++++++++++++++++++++
 3 files changed

// File: rtl/eth_pkg.sv
// Shared Ethernet constants, FSM state type and CRC helpers for the MAC datapath.
package eth_pkg;

  localparam logic [7:0]  PREAMBLE_BYTE = 8'h55;
  localparam logic [7:0]  SFD_BYTE      = 8'hD5;
  localparam logic [31:0] CRC_POLY      = 32'h04C11DB7;
  localparam logic [31:0] CRC_INIT      = 32'hFFFFFFFF;
  localparam logic [31:0] CRC_RESIDUE   = 32'hC704DD7B;

  localparam int unsigned PREAMBLE_LEN  = 7;
  localparam int unsigned FCS_LEN       = 4;

  typedef enum logic [2:0] {
    StIdle,
    StPreamble,
    StSfd,
    StData,
    StPad,
    StFcs,
    StIfg
  } tx_state_e;

  // Bit-reverse a 32-bit word; the LSB-first CRC engine needs the reflected polynomial.
  function automatic logic [31:0] reflect32(input logic [31:0] v);
    logic [31:0] r;
    for (int i = 0; i < 32; i++) begin
      r[i] = v[31-i];
    end
    return r;
  endfunction

endpackage

// File: rtl/eth_crc32.sv
// Combinational byte-wide CRC-32 step (reflected, LSB first). No final inversion here.
module eth_crc32
  import eth_pkg::*;
(
  input  logic [31:0] i_crc,
  input  logic [7:0]  i_data,
  output logic [31:0] o_crc
);

  localparam logic [31:0] CRC_POLY_REFL = reflect32(CRC_POLY);

  logic [31:0] w_acc;

  // Eight serial shift steps unrolled into one combinational stage.
  always_comb begin
    w_acc = i_crc ^ {24'h000000, i_data};
    for (int i = 0; i < 8; i++) begin
      if (w_acc[0]) begin
        w_acc = (w_acc >> 1) ^ CRC_POLY_REFL;
      end else begin
        w_acc = w_acc >> 1;
      end
    end
    o_crc = w_acc;
  end

endmodule

// File: rtl/eth_mac_tx.sv
// Ethernet MAC transmit path: preamble/SFD, data, zero padding, FCS and inter-frame gap
// onto an MII (nibble, low first) or GMII (byte) lane.
module eth_mac_tx
  import eth_pkg::*;
#(
  parameter int unsigned MII_W     = 4,
  parameter int unsigned MIN_FRAME = 60,
  parameter int unsigned IFG_BYTES = 12
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_tvalid,
  input  logic [7:0]       in_tdata,
  input  logic             in_tlast,
  output logic             in_tready,
  output logic [MII_W-1:0] mii_txd,
  output logic             mii_txen,
  output logic             mii_txer,
  output logic             busy,
  output logic             frame_done,
  output logic             underrun
);

  localparam bit          NIBBLE   = (MII_W == 4);
  localparam logic [15:0] MIN_CNT  = 16'(MIN_FRAME);
  localparam logic [15:0] IFG_LAST = 16'(IFG_BYTES - 1);
  localparam logic [15:0] PRE_LAST = 16'(PREAMBLE_LEN - 1);
  localparam logic [15:0] FCS_LAST = 16'(FCS_LEN - 1);

  tx_state_e        r_state;
  logic             r_phase;
  logic [15:0]      r_cnt;
  logic [15:0]      r_bcnt;
  logic [31:0]      r_crc;
  logic [MII_W-1:0] r_hi;
  logic [MII_W-1:0] r_txd;
  logic             r_txen;
  logic             r_txer;
  logic             r_done;
  logic             r_underrun;

  logic             w_beat_end;
  logic [15:0]      w_bcnt_inc;
  logic [7:0]       w_crc_byte;
  logic [31:0]      w_crc_next;
  logic [31:0]      w_fcs;
  logic [7:0]       w_fcs_byte;
  logic [7:0]       w_byte;
  logic             w_en;
  logic             w_er;

  // In nibble mode a byte-time spans two clocks; all state advances on its second clock.
  assign w_beat_end = NIBBLE ? r_phase : 1'b1;
  assign w_bcnt_inc = (r_bcnt >= MIN_CNT) ? r_bcnt : r_bcnt + 16'd1;
  assign w_crc_byte = (r_state == StData) ? in_tdata : 8'h00;
  assign w_fcs      = ~r_crc;
  assign w_fcs_byte = w_fcs[{r_cnt[1:0], 3'b000} +: 8];

  assign in_tready  = (r_state == StData) && w_beat_end;
  assign busy       = (r_state != StIdle);
  assign mii_txd    = r_txd;
  assign mii_txen   = r_txen;
  assign mii_txer   = r_txer;
  assign frame_done = r_done;
  assign underrun   = r_underrun;

  eth_crc32 u_crc (
    .i_crc  (r_crc),
    .i_data (w_crc_byte),
    .o_crc  (w_crc_next)
  );

  // Byte and line flags to launch for the next byte-time, decoded from the current state.
  always_comb begin
    w_byte = 8'h00;
    w_en   = 1'b0;
    w_er   = 1'b0;
    unique case (r_state)
      StIdle: begin
        if (in_tvalid) begin
          w_byte = PREAMBLE_BYTE;
          w_en   = 1'b1;
        end
      end
      StPreamble: begin
        w_byte = PREAMBLE_BYTE;
        w_en   = 1'b1;
      end
      StSfd: begin
        w_byte = SFD_BYTE;
        w_en   = 1'b1;
      end
      StData: begin
        w_en = 1'b1;
        if (in_tvalid) begin
          w_byte = in_tdata;
        end else begin
          w_er = 1'b1;
        end
      end
      StPad: begin
        w_en = 1'b1;
      end
      StFcs: begin
        w_byte = w_fcs_byte;
        w_en   = 1'b1;
      end
      StIfg: begin
        w_en = 1'b0;
      end
      default: begin
        w_en = 1'b0;
      end
    endcase
  end

  // Frame FSM, counters, CRC register and registered MII outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state    <= StIdle;
      r_phase    <= 1'b0;
      r_cnt      <= 16'd0;
      r_bcnt     <= 16'd0;
      r_crc      <= CRC_INIT;
      r_hi       <= '0;
      r_txd      <= '0;
      r_txen     <= 1'b0;
      r_txer     <= 1'b0;
      r_done     <= 1'b0;
      r_underrun <= 1'b0;
    end else begin
      r_phase    <= NIBBLE ? ~r_phase : 1'b0;
      r_done     <= 1'b0;
      r_underrun <= 1'b0;
      if (!w_beat_end) begin
        // Second half of a nibble-mode byte-time: push out the stored high nibble.
        r_txd <= r_hi;
      end else begin
        r_txd  <= w_byte[MII_W-1:0];
        r_hi   <= MII_W'(w_byte >> 4);
        r_txen <= w_en;
        r_txer <= w_er;
        unique case (r_state)
          StIdle: begin
            // The first preamble byte is launched here, so the counter starts at one.
            if (in_tvalid) begin
              r_state <= StPreamble;
              r_cnt   <= 16'd1;
              r_bcnt  <= 16'd0;
              r_crc   <= CRC_INIT;
            end
          end
          StPreamble: begin
            if (r_cnt == PRE_LAST) begin
              r_state <= StSfd;
            end else begin
              r_cnt <= r_cnt + 16'd1;
            end
          end
          StSfd: begin
            r_state <= StData;
          end
          StData: begin
            if (in_tvalid) begin
              r_crc  <= w_crc_next;
              r_bcnt <= w_bcnt_inc;
              if (in_tlast) begin
                r_cnt   <= 16'd0;
                r_state <= (w_bcnt_inc < MIN_CNT) ? StPad : StFcs;
              end
            end else begin
              r_underrun <= 1'b1;
              r_cnt      <= 16'd0;
              r_state    <= StIfg;
            end
          end
          StPad: begin
            r_crc  <= w_crc_next;
            r_bcnt <= w_bcnt_inc;
            if (w_bcnt_inc >= MIN_CNT) begin
              r_cnt   <= 16'd0;
              r_state <= StFcs;
            end
          end
          StFcs: begin
            if (r_cnt == FCS_LAST) begin
              r_done  <= 1'b1;
              r_cnt   <= 16'd0;
              r_state <= StIfg;
            end else begin
              r_cnt <= r_cnt + 16'd1;
            end
          end
          StIfg: begin
            if (r_cnt == IFG_LAST) begin
              r_cnt   <= 16'd0;
              r_state <= StIdle;
            end else begin
              r_cnt <= r_cnt + 16'd1;
            end
          end
          default: begin
            r_state <= StIdle;
          end
        endcase
      end
    end
  end

endmodule
